// File: rtl/cla_adder_8bit.sv
// Signed 8-bit two-level carry-lookahead adder with a registered 9-bit sum
// and an 8-bit signed overflow flag; one cycle of latency.
module cla_adder_8bit #(
   parameter int N = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic signed [N-1:0] A,
   input  logic signed [N-1:0] B,
   output logic signed [N:0]   S,
   output logic                ovf8
);

   typedef struct packed {
      logic       gp;   // group propagate
      logic       gg;   // group generate
      logic [3:0] c;    // carries into bits 0..3 of the group
   } cla4_t;

   // Each in-group carry is a flat sum of products, so no carry ripples.
   function automatic cla4_t cla4(input logic [3:0] g,
                                  input logic [3:0] p,
                                  input logic       cin);
      cla4_t r;
      r.c[0] = cin;
      r.c[1] = g[0] | (p[0] & cin);
      r.c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
      r.c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & cin);
      r.gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]);
      r.gp   = &p;
      return r;
   endfunction

   logic [N-1:0] g;
   logic [N-1:0] p;
   logic [N-1:0] carry;
   logic         c0;
   logic         c4;
   logic         c8;
   cla4_t        lo;
   cla4_t        hi;
   logic [N:0]   sum;
   logic         ovf;

   always_comb begin
      c0    = 1'b0;
      g     = A & B;
      p     = A ^ B;
      lo    = cla4(g[3:0], p[3:0], c0);
      c4    = lo.gg | (lo.gp & c0);
      hi    = cla4(g[7:4], p[7:4], c4);
      c8    = hi.gg | (hi.gp & lo.gg) | (hi.gp & lo.gp & c0);
      carry = {hi.c, lo.c};
      // MSB is the sign extension of the 9-bit result, not the raw carry-out
      sum   = {A[N-1] ^ B[N-1] ^ c8, p ^ carry};
      ovf   = c8 ^ carry[N-1];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         S    <= '0;
         ovf8 <= 1'b0;
      end else begin
         S    <= sum;
         ovf8 <= ovf;
      end
   end

endmodule

// File: tb/tb_cla_adder_8bit.sv
// Self-checking bench for cla_adder_8bit: directed corner cases, a boundary
// sweep and random operand pairs checked against integer arithmetic.
module tb_cla_adder_8bit;

   logic               clk;
   logic               rst;
   logic signed [7:0]  A;
   logic signed [7:0]  B;
   logic signed [8:0]  S;
   logic               ovf8;

   int n_checks;
   int n_fail;

   cla_adder_8bit #(.N(8)) dut (
      .clk  (clk),
      .rst  (rst),
      .A    (A),
      .B    (B),
      .S    (S),
      .ovf8 (ovf8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_out(input string tag, input int exp_s, input logic exp_ovf);
      n_checks++;
      assert (int'(S) === exp_s) else begin
         n_fail++;
         $error("FAIL %s S: got %0d expected %0d", tag, int'(S), exp_s);
      end
      n_checks++;
      assert (ovf8 === exp_ovf) else begin
         n_fail++;
         $error("FAIL %s ovf8: got %0b expected %0b", tag, ovf8, exp_ovf);
      end
   endtask

   // Drive at a falling edge, check just after the next rising edge, hold 20 ns.
   task automatic apply(input string tag, input int a, input int b);
      int sum;
      A = 8'(a);
      B = 8'(b);
      sum = a + b;
      @(posedge clk);
      #1;
      check_out($sformatf("%s(%0d,%0d)", tag, a, b), sum, (sum < -128) || (sum > 127));
      @(negedge clk);
      @(negedge clk);
   endtask

   initial begin
      int a;
      int b;
      int exp_seq [3];
      int ta [3];
      int tb [3];
      n_checks = 0;
      n_fail   = 0;

      // reset applied with operands already present
      A   = 8'sd5;
      B   = 8'sd3;
      rst = 1'b1;
      #3;
      check_out("reset_init", 0, 1'b0);
      @(posedge clk);
      #1;
      check_out("reset_held", 0, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check_out("reset_release", 8, 1'b0);
      @(negedge clk);

      // directed corners
      apply("ext_neg", -128, -128);
      apply("ext_pos", 127, 127);
      apply("zero_a", -1, 1);
      apply("zero_b", 127, -127);
      apply("ovf_up", 127, 1);
      apply("ovf_dn", -128, -1);
      apply("edge_min", -128, 0);
      apply("edge_max", 127, 0);
      apply("edge_m128", -64, -64);
      apply("carry_chain", 15, 1);

      // asynchronous reset mid-stream: output clears without a clock edge
      apply("pre_rst", 50, 50);
      #2;
      rst = 1'b1;
      #1;
      check_out("reset_async", 0, 1'b0);
      @(negedge clk);
      A   = 8'sd5;
      B   = 8'sd3;
      rst = 1'b0;
      @(posedge clk);
      #1;
      check_out("reset_first", 8, 1'b0);
      @(negedge clk);

      // back-to-back: new operands every cycle
      ta = '{1, -2, 100};
      tb = '{1, -3, 100};
      exp_seq = '{2, -5, 200};
      for (int i = 0; i < 3; i++) begin
         A = 8'(ta[i]);
         B = 8'(tb[i]);
         @(posedge clk);
         #1;
         check_out($sformatf("b2b%0d", i), exp_seq[i], (exp_seq[i] > 127) || (exp_seq[i] < -128));
         @(negedge clk);
      end

      // every A against the boundary B values
      for (int i = -128; i <= 127; i++) begin
         apply("sweep_bmin", i, -128);
         apply("sweep_bmax", i, 127);
         apply("sweep_bneg1", i, -1);
         apply("sweep_bone", i, 1);
      end

      // random operand pairs
      for (int i = 0; i < 3000; i++) begin
         a = int'($urandom_range(255)) - 128;
         b = int'($urandom_range(255)) - 128;
         apply("rand", a, b);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
